// File: rtl/slicer_32x16.sv
// ---------------------------------------------------------------------------
// slicer_32x16
//   Registered word slicer between the 32-bit value mux and the board outputs.
//   A load strobe captures the word. One half goes to the 7-segment display
//   path and the other half goes to the LED bank. Both halves then hold until
//   the next load. The swap input selects which half reaches the display.
//   out_valid pulses in the cycle after every capture.
//
//   Optional feature macro: SLICER_CHANGE_DETECT_EN
//     When defined, the block adds a registered 'changed' output. It pulses
//     together with out_valid when the captured word (before the swap)
//     differs from the word captured previously.
// ---------------------------------------------------------------------------
module slicer_32x16 #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  mux_out,
    input  logic             load,
    input  logic             swap,
    output logic [OUT_W-1:0] value_to_display,
    output logic [OUT_W-1:0] value_to_LEDs,
    output logic             out_valid
`ifdef SLICER_CHANGE_DETECT_EN
    ,
    output logic             changed
`endif
);

    // The word must split exactly into two output halves.
    if (IN_W != 2 * OUT_W) begin : g_width_check
        $error("slicer_32x16: IN_W (%0d) must equal 2*OUT_W (%0d)", IN_W, 2 * OUT_W);
    end

    logic [OUT_W-1:0] disp_q, disp_d;
    logic [OUT_W-1:0] led_q,  led_d;
    logic             valid_q, valid_d;

`ifdef SLICER_CHANGE_DETECT_EN
    logic [IN_W-1:0]  prev_q, prev_d;
    logic             changed_q, changed_d;
`endif

    // Next-state logic: select the halves on load, otherwise hold them.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        disp_d  = disp_q;
        led_d   = led_q;
        valid_d = load;
        if (load) begin
            if (swap) begin
                disp_d = mux_out[OUT_W-1:0];
                led_d  = mux_out[IN_W-1:OUT_W];
            end else begin
                disp_d = mux_out[IN_W-1:OUT_W];
                led_d  = mux_out[OUT_W-1:0];
            end
        end
`ifdef SLICER_CHANGE_DETECT_EN
        prev_d    = prev_q;
        changed_d = 1'b0;
        if (load) begin
            prev_d    = mux_out;
            changed_d = (mux_out != prev_q);
        end
`endif
    end

    // State registers; rst clears them asynchronously, so any pending capture is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every register samples values from before the edge.
            disp_q    <= '0;
            led_q     <= '0;
            valid_q   <= 1'b0;
`ifdef SLICER_CHANGE_DETECT_EN
            prev_q    <= '0;
            changed_q <= 1'b0;
`endif
        end else begin
            disp_q    <= disp_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
`ifdef SLICER_CHANGE_DETECT_EN
            prev_q    <= prev_d;
            changed_q <= changed_d;
`endif
        end
    end

    assign value_to_display = disp_q;
    assign value_to_LEDs    = led_q;
    assign out_valid        = valid_q;
`ifdef SLICER_CHANGE_DETECT_EN
    assign changed          = changed_q;
`endif

endmodule

// File: tb/tb_slicer_32x16.sv
// ---------------------------------------------------------------------------
// tb_slicer_32x16
//   Directed bench for slicer_32x16. Inputs are driven 1 ns after each rising
//   edge, and outputs are sampled at that same point. Expected values are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_slicer_32x16;

    logic        clk;
    logic        rst;
    logic [31:0] mux_out;
    logic        load;
    logic        swap;
    logic [15:0] value_to_display;
    logic [15:0] value_to_LEDs;
    logic        out_valid;
`ifdef SLICER_CHANGE_DETECT_EN
    logic        changed;
`endif

    int checks   = 0;
    int failures = 0;

    slicer_32x16 #(.IN_W(32), .OUT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .mux_out          (mux_out),
        .load             (load),
        .swap             (swap),
        .value_to_display (value_to_display),
        .value_to_LEDs    (value_to_LEDs),
        .out_valid        (out_valid)
`ifdef SLICER_CHANGE_DETECT_EN
        ,
        .changed          (changed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse load for one edge; the outputs are then visible on return.
    task automatic load_pulse(input logic [31:0] word, input logic sw);
        mux_out = word;
        swap    = sw;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic test_reset();
        logic [32:0] exp;
        // Reset applied at time zero
        #1;
        exp = {16'h0000, 16'h0000, 1'b0};
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== exp) begin
            failures++;
            $display("FAIL reset_initial got=%h exp=%h", {value_to_display, value_to_LEDs, out_valid}, exp);
        end
        tick();
        rst = 1'b0;
        // Load a nonzero word, then assert rst between edges
        load_pulse(32'hDEAD_BEEF, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== exp) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", {value_to_display, value_to_LEDs, out_valid}, exp);
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== exp) begin
            failures++;
            $display("FAIL reset_release_idle got=%h exp=%h", {value_to_display, value_to_LEDs, out_valid}, exp);
        end
    endtask

    task automatic test_basic_slice();
        load_pulse(32'h0123_4567, 1'b0);
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== {16'h0123, 16'h4567, 1'b1}) begin
            failures++;
            $display("FAIL basic_slice got=%h_%h v=%b exp=0123_4567 v=1", value_to_display, value_to_LEDs, out_valid);
        end
        tick();
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== {16'h0123, 16'h4567, 1'b0}) begin
            failures++;
            $display("FAIL basic_valid_drop got=%h_%h v=%b exp=0123_4567 v=0", value_to_display, value_to_LEDs, out_valid);
        end
    endtask

    task automatic test_hold();
        load_pulse(32'h89AB_CDEF, 1'b0);
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== {16'h89AB, 16'hCDEF, 1'b1}) begin
            failures++;
            $display("FAIL second_word got=%h_%h v=%b exp=89ab_cdef v=1", value_to_display, value_to_LEDs, out_valid);
        end
        mux_out = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            swap = i[0];
            tick();
            checks++;
            if ({value_to_display, value_to_LEDs, out_valid} !== {16'h89AB, 16'hCDEF, 1'b0}) begin
                failures++;
                $display("FAIL hold_cycle%0d got=%h_%h v=%b exp=89ab_cdef v=0", i, value_to_display, value_to_LEDs, out_valid);
            end
        end
    endtask

    task automatic test_swap();
        load_pulse(32'h89AB_CDEF, 1'b1);
        swap = 1'b0;
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== {16'hCDEF, 16'h89AB, 1'b1}) begin
            failures++;
            $display("FAIL swap got=%h_%h v=%b exp=cdef_89ab v=1", value_to_display, value_to_LEDs, out_valid);
        end
        load_pulse(32'h8000_0001, 1'b1);
        checks++;
        if ({value_to_display, value_to_LEDs} !== {16'h0001, 16'h8000}) begin
            failures++;
            $display("FAIL swap_msb_lsb got=%h_%h exp=0001_8000", value_to_display, value_to_LEDs);
        end
    endtask

    task automatic test_back_to_back();
        swap    = 1'b0;
        mux_out = 32'h0123_4567;
        load    = 1'b1;
        tick();
        mux_out = 32'h89AB_CDEF;
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== {16'h0123, 16'h4567, 1'b1}) begin
            failures++;
            $display("FAIL b2b_first got=%h_%h v=%b exp=0123_4567 v=1", value_to_display, value_to_LEDs, out_valid);
        end
        tick();
        load = 1'b0;
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== {16'h89AB, 16'hCDEF, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second got=%h_%h v=%b exp=89ab_cdef v=1", value_to_display, value_to_LEDs, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got v=%b exp v=0", out_valid);
        end
        // Recapturing the same word must still pulse out_valid
        load_pulse(32'h89AB_CDEF, 1'b0);
        checks++;
        if ({value_to_display, value_to_LEDs, out_valid} !== {16'h89AB, 16'hCDEF, 1'b1}) begin
            failures++;
            $display("FAIL recapture_same got=%h_%h v=%b exp=89ab_cdef v=1", value_to_display, value_to_LEDs, out_valid);
        end
        tick();
    endtask

`ifdef SLICER_CHANGE_DETECT_EN
    task automatic test_change_detect();
        logic [31:0] words [3] = '{32'h0123_4567, 32'h0123_4567, 32'h89AB_CDEF};
        logic        exp_c [3] = '{1'b1, 1'b0, 1'b1};
        // Start from a cleared previous-word register
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_pulse(words[i], 1'b0);
            checks++;
            if ({changed, out_valid} !== {exp_c[i], 1'b1}) begin
                failures++;
                $display("FAIL changed_seq%0d got c=%b v=%b exp c=%b v=1", i, changed, out_valid, exp_c[i]);
            end
            tick();
            checks++;
            if (changed !== 1'b0) begin
                failures++;
                $display("FAIL changed_drop%0d got=%b exp=0", i, changed);
            end
        end
        // A swap-only change of the same word is not a change
        load_pulse(32'h89AB_CDEF, 1'b1);
        swap = 1'b0;
        checks++;
        if (changed !== 1'b0) begin
            failures++;
            $display("FAIL changed_swap_only got=%b exp=0", changed);
        end
        // Reset clears the flag and the previous word; zero then matches
        load = 1'b1;
        mux_out = 32'h1111_1111;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (changed !== 1'b0) begin
            failures++;
            $display("FAIL changed_reset got=%b exp=0", changed);
        end
        load = 1'b0;
        tick();
        rst = 1'b0;
        load_pulse(32'h0000_0000, 1'b0);
        checks++;
        if ({changed, out_valid} !== 2'b01) begin
            failures++;
            $display("FAIL changed_prev_cleared got c=%b v=%b exp c=0 v=1", changed, out_valid);
        end
        tick();
    endtask
`endif

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        swap    = 1'b0;
        mux_out = 32'h0;
        test_reset();
        test_basic_slice();
        test_hold();
        test_swap();
        test_back_to_back();
`ifdef SLICER_CHANGE_DETECT_EN
        test_change_detect();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
